// File: rtl/axi_lite_inputs_capture.sv
// AXI4-Lite leaf slave: synchronises NUM_CH input words, latches per-channel changes into a
// W1C status register and drives a maskable, registered level interrupt.
module axi_lite_inputs_capture #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic                         irq,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = ADDR_WIDTH - 2;

  localparam logic [IDX_W-1:0] IDX_CTRL    = IDX_W'(32'd0);
  localparam logic [IDX_W-1:0] IDX_STATUS  = IDX_W'(32'd1);
  localparam logic [IDX_W-1:0] IDX_MASK    = IDX_W'(32'd2);
  localparam logic [IDX_W-1:0] IDX_SCRATCH = IDX_W'(32'd3);
  localparam logic [IDX_W-1:0] IDX_CH0     = IDX_W'(32'd4);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  function automatic logic [DATA_WIDTH-1:0] strb_mask(input logic [STRB_W-1:0] strb);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int k = 0; k < STRB_W; k++) begin
      m[8*k +: 8] = {8{strb[k]}};
    end
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] implemented_ch_bits();
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [DATA_WIDTH-1:0] CH_MASK = implemented_ch_bits();

  logic [NUM_CH*DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH*DATA_WIDTH-1:0] ch_val;
  logic [NUM_CH*DATA_WIDTH-1:0] prev;
  logic                         armed;
  logic [DATA_WIDTH-1:0]        change;

  logic [0:0]            wstate;
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  do_write;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wmask;

  logic [0:0]            rstate;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] ch_rd;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  gie;
  logic [DATA_WIDTH-1:0] status;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] scratch;
  logic                  gie_next;
  logic [DATA_WIDTH-1:0] status_next;
  logic [DATA_WIDTH-1:0] mask_next;
  logic [DATA_WIDTH-1:0] scratch_next;
  logic [DATA_WIDTH-1:0] w1c;

  logic unused;

  assign ch_val      = sync_q[SYNC_STAGES-1];
  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;
  assign do_write    = (wstate == W_IDLE) && aw_held && w_held;
  assign wr_idx      = aw_addr[ADDR_WIDTH-1:2];
  assign rd_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign unused      = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr[1:0], S_AXI_ARADDR[1:0]};

  // Input synchroniser chain plus previous-sample register; armed masks the first sample
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev  <= '0;
      armed <= 1'b0;
    end else begin
      sync_q[0] <= in_data;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev  <= ch_val;
      armed <= 1'b1;
    end
  end

  // Per-channel change detection against the previous synchronised sample
  always_comb begin
    change = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      change[i] = armed && (ch_val[i*DATA_WIDTH +: DATA_WIDTH] != prev[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Next-state of the control registers; a hardware set beats a same-cycle W1C
  always_comb begin
    wmask        = strb_mask(w_strb);
    gie_next     = gie;
    mask_next    = mask;
    scratch_next = scratch;
    w1c          = '0;
    if (do_write) begin
      case (wr_idx)
        IDX_CTRL:    gie_next     = w_strb[0] ? w_data[0] : gie;
        IDX_STATUS:  w1c          = w_data & wmask;
        IDX_MASK:    mask_next    = ((mask & ~wmask) | (w_data & wmask)) & CH_MASK;
        IDX_SCRATCH: scratch_next = (scratch & ~wmask) | (w_data & wmask);
        default:     w1c          = '0;
      endcase
    end else begin
      w1c = '0;
    end
    status_next = ((status & ~w1c) | change) & CH_MASK;
  end

  // Register file and interrupt; irq follows the next-state so it tracks STATUS in the same cycle
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      gie     <= 1'b0;
      status  <= '0;
      mask    <= '0;
      scratch <= '0;
      irq     <= 1'b0;
    end else begin
      gie     <= gie_next;
      status  <= status_next;
      mask    <= mask_next;
      scratch <= scratch_next;
      irq     <= gie_next && (|(status_next & mask_next));
    end
  end

  // Write channel: AW and W latched independently, update once both are held
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate        <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr       <= '0;
      w_data        <= '0;
      w_strb        <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_held && w_held) begin
            wstate       <= W_RESP;
            S_AXI_BVALID <= 1'b1;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
          end else begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
              aw_held       <= 1'b1;
              aw_addr       <= S_AXI_AWADDR;
              S_AXI_AWREADY <= 1'b0;
            end else if (!aw_held) begin
              S_AXI_AWREADY <= 1'b1;
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
              w_held       <= 1'b1;
              w_data       <= S_AXI_WDATA;
              w_strb       <= S_AXI_WSTRB;
              S_AXI_WREADY <= 1'b0;
            end else if (!w_held) begin
              S_AXI_WREADY <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            wstate        <= W_IDLE;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
          end
        end
        default: begin
          wstate        <= W_IDLE;
          S_AXI_BVALID  <= 1'b0;
          S_AXI_AWREADY <= 1'b0;
          S_AXI_WREADY  <= 1'b0;
          aw_held       <= 1'b0;
          w_held        <= 1'b0;
        end
      endcase
    end
  end

  // Read decode; channel words are OR-selected so unmapped indices fall out as zero
  always_comb begin
    ch_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_rd = ch_rd | ({DATA_WIDTH{rd_idx == (IDX_CH0 + IDX_W'(i))}} &
                       ch_val[i*DATA_WIDTH +: DATA_WIDTH]);
    end
    case (rd_idx)
      IDX_CTRL:    rd_word = {{(DATA_WIDTH-1){1'b0}}, gie};
      IDX_STATUS:  rd_word = status;
      IDX_MASK:    rd_word = mask;
      IDX_SCRATCH: rd_word = scratch;
      default:     rd_word = ch_rd;
    endcase
  end

  // Read channel: data captured on the AR handshake and held until RREADY
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate        <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            rstate        <= R_DATA;
            S_AXI_RDATA   <= rd_word;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_ARREADY <= 1'b0;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rstate        <= R_IDLE;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
          end
        end
        default: begin
          rstate        <= R_IDLE;
          S_AXI_RVALID  <= 1'b0;
          S_AXI_ARREADY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_inputs_capture.sv
// Self-checking bench for axi_lite_inputs_capture: register vector table plus hand-written
// sequences for synchroniser latency, interrupt, handshake ordering, W1C race and reset.
module tb_axi_lite_inputs_capture;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int NCH = 4;
  localparam int SS  = 2;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic [NCH*DW-1:0] in_data;
  logic              irq;
  logic [AW-1:0]     S_AXI_AWADDR;
  logic [2:0]        S_AXI_AWPROT;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [DW-1:0]     S_AXI_WDATA;
  logic [DW/8-1:0]   S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [AW-1:0]     S_AXI_ARADDR;
  logic [2:0]        S_AXI_ARPROT;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [DW-1:0]     S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  always #5 ACLK = ~ACLK;

  axi_lite_inputs_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH), .SYNC_STAGES(SS)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .in_data(in_data), .irq(irq),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY)
  );

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;

  int   compared   = 0;
  int   mismatched = 0;
  sb_t  sb_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input string what);
    compared++;
    mismatched++;
    $display("FAIL %s: got no %s expected it within 50 cycles", name, what);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_bvalid(input string name, output bit ok);
    int n;
    n = 0;
    while (!S_AXI_BVALID && n < 50) begin
      tick();
      n++;
    end
    ok = S_AXI_BVALID;
    if (!ok) timeout(name, "BVALID");
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input string name);
    bit aw_done, w_done, aw_fire, w_fire, ok;
    int n;
    aw_done = 1'b0;
    w_done  = 1'b0;
    n       = 0;
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      n++;
      if (aw_fire) begin aw_done = 1'b1; S_AXI_AWVALID = 1'b0; end
      if (w_fire)  begin w_done  = 1'b1; S_AXI_WVALID  = 1'b0; end
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    if (!(aw_done && w_done)) begin
      timeout(name, "AW/W handshake");
      return;
    end
    S_AXI_BREADY = 1'b1;
    wait_bvalid(name, ok);
    if (ok) check({name, " bresp"}, 32'(S_AXI_BRESP), 32'h0);
    tick();
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp, input string name);
    bit fired, fire;
    int n;
    sb_t e;
    sb_q.push_back('{exp, name});
    fired = 1'b0;
    n     = 0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    while (!fired && n < 50) begin
      fire = S_AXI_ARVALID && S_AXI_ARREADY;
      tick();
      n++;
      if (fire) begin fired = 1'b1; S_AXI_ARVALID = 1'b0; end
    end
    S_AXI_ARVALID = 1'b0;
    e = sb_q.pop_front();
    if (!fired) begin
      timeout(e.name, "AR handshake");
      return;
    end
    S_AXI_RREADY = 1'b1;
    n = 0;
    while (!S_AXI_RVALID && n < 50) begin
      tick();
      n++;
    end
    if (!S_AXI_RVALID) begin
      timeout(e.name, "RVALID");
    end else begin
      check(e.name, S_AXI_RDATA, e.exp);
      check({e.name, " rresp"}, 32'(S_AXI_RRESP), 32'h0);
      tick();
    end
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected it before 500 us");
    $fatal(1);
  end

  initial begin
    bit ok;
    ARESET = 1'b1;
    in_data = '0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = 3'd0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = 3'd0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    repeat (3) tick();

    check("rst awready", 32'(S_AXI_AWREADY), 32'h0);
    check("rst wready", 32'(S_AXI_WREADY), 32'h0);
    check("rst arready", 32'(S_AXI_ARREADY), 32'h0);
    check("rst bvalid", 32'(S_AXI_BVALID), 32'h0);
    check("rst rvalid", 32'(S_AXI_RVALID), 32'h0);
    check("rst rdata", S_AXI_RDATA, 32'h0);
    check("rst irq", 32'(irq), 32'h0);
    ARESET = 1'b0;
    repeat (2) tick();

    vecs.push_back('{1'b0, 8'h00, 32'h0, 4'h0, 32'h0, "rst CTRL"});
    vecs.push_back('{1'b0, 8'h04, 32'h0, 4'h0, 32'h0, "rst STATUS"});
    vecs.push_back('{1'b0, 8'h08, 32'h0, 4'h0, 32'h0, "rst MASK"});
    vecs.push_back('{1'b0, 8'h0C, 32'h0, 4'h0, 32'h0, "rst SCRATCH"});
    vecs.push_back('{1'b1, 8'h0C, 32'h1, 4'hF, 32'h0, "wr SCRATCH 1"});
    vecs.push_back('{1'b1, 8'h00, 32'h1, 4'hF, 32'h0, "wr CTRL 1"});
    vecs.push_back('{1'b1, 8'h08, 32'hF, 4'hF, 32'h0, "wr MASK F"});
    vecs.push_back('{1'b0, 8'h0C, 32'h0, 4'h0, 32'h1, "rd SCRATCH 1"});
    vecs.push_back('{1'b0, 8'h00, 32'h0, 4'h0, 32'h1, "rd CTRL 1"});
    vecs.push_back('{1'b0, 8'h08, 32'h0, 4'h0, 32'hF, "rd MASK F"});
    vecs.push_back('{1'b1, 8'h0C, 32'hA5A5_1234, 4'h5, 32'h0, "wr SCRATCH strb5"});
    vecs.push_back('{1'b0, 8'h0C, 32'h0, 4'h0, 32'h00A5_0034, "rd SCRATCH strb5"});
    vecs.push_back('{1'b1, 8'h00, 32'hFFFF_FFFF, 4'hF, 32'h0, "wr CTRL all"});
    vecs.push_back('{1'b0, 8'h00, 32'h0, 4'h0, 32'h1, "rd CTRL only gie"});
    vecs.push_back('{1'b1, 8'h08, 32'hFFFF_FFFF, 4'hF, 32'h0, "wr MASK all"});
    vecs.push_back('{1'b0, 8'h08, 32'h0, 4'h0, 32'hF, "rd MASK NUM_CH bits"});
    vecs.push_back('{1'b0, 8'h0B, 32'h0, 4'h0, 32'hF, "rd MASK low addr bits"});
    vecs.push_back('{1'b1, 8'h10, 32'h1234_5678, 4'hF, 32'h0, "wr CH0 ignored"});
    vecs.push_back('{1'b0, 8'h10, 32'h0, 4'h0, 32'h0, "rd CH0"});
    vecs.push_back('{1'b0, 8'h1C, 32'h0, 4'h0, 32'h0, "rd CH3"});
    vecs.push_back('{1'b0, 8'h20, 32'h0, 4'h0, 32'h0, "rd past last CH"});
    vecs.push_back('{1'b0, 8'h40, 32'h0, 4'h0, 32'h0, "rd unmapped"});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].name);
      else               axi_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end

    // channel 2 capture and change latency (gie=1, MASK=0xF)
    in_data[2*DW +: DW] = 32'hDEAD_BEEF;
    repeat (SS) tick();
    check("irq before status set", 32'(irq), 32'h0);
    tick();
    check("irq one cycle after CH", 32'(irq), 32'h1);
    axi_read(8'h18, 32'hDEAD_BEEF, "rd CH2");
    axi_read(8'h04, 32'h4, "rd STATUS ch2");

    // masking and W1C clear of the interrupt
    axi_write(8'h08, 32'h4, 4'hF, "wr MASK 4");
    check("irq with MASK 4", 32'(irq), 32'h1);
    axi_write(8'h04, 32'h4, 4'hF, "w1c STATUS 4");
    check("irq after W1C", 32'(irq), 32'h0);
    axi_read(8'h04, 32'h0, "rd STATUS cleared");
    in_data[2*DW +: DW] = 32'h0;
    repeat (SS) tick();
    check("irq ch2 toggle early", 32'(irq), 32'h0);
    tick();
    check("irq ch2 toggle", 32'(irq), 32'h1);
    axi_write(8'h04, 32'h4, 4'hF, "w1c STATUS 4 again");
    check("irq after second W1C", 32'(irq), 32'h0);
    in_data[0 +: DW] = 32'h0000_005A;
    repeat (SS + 2) tick();
    check("irq ch0 masked", 32'(irq), 32'h0);
    axi_read(8'h04, 32'h1, "rd STATUS ch0");
    axi_write(8'h04, 32'h1, 4'hF, "w1c STATUS 1");

    // hardware set of bit1 coincides with W1C of bit1
    in_data[1*DW +: DW] = 32'h11;
    repeat (SS + 2) tick();
    axi_read(8'h04, 32'h2, "rd STATUS ch1");
    in_data[1*DW +: DW] = 32'h22;
    repeat (SS - 1) tick();
    check("race awready", 32'(S_AXI_AWREADY), 32'h1);
    check("race wready", 32'(S_AXI_WREADY), 32'h1);
    S_AXI_AWADDR = 8'h04; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h2; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    wait_bvalid("race write", ok);
    tick();
    S_AXI_BREADY = 1'b0;
    axi_read(8'h04, 32'h2, "STATUS set beats W1C");
    axi_write(8'h04, 32'hFFFF_FFFF, 4'hE, "w1c strb E");
    axi_read(8'h04, 32'h2, "rd STATUS strb E kept");
    axi_write(8'h04, 32'h2, 4'h1, "w1c strb 1");
    axi_read(8'h04, 32'h0, "rd STATUS strb 1 cleared");

    // W leads AW by 3 cycles, BREADY held low for 5 cycles
    check("ooo wready idle", 32'(S_AXI_WREADY), 32'h1);
    S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    check("ooo wready dropped", 32'(S_AXI_WREADY), 32'h0);
    repeat (2) tick();
    check("ooo no bvalid without AW", 32'(S_AXI_BVALID), 32'h0);
    check("ooo awready waiting", 32'(S_AXI_AWREADY), 32'h1);
    S_AXI_AWADDR = 8'h0C; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    wait_bvalid("ooo write", ok);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("ooo bvalid held %0d", i), 32'(S_AXI_BVALID), 32'h1);
      tick();
    end
    check("ooo bresp", 32'(S_AXI_BRESP), 32'h0);
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("ooo bvalid released", 32'(S_AXI_BVALID), 32'h0);
    axi_read(8'h0C, 32'hCAFE_F00D, "rd SCRATCH ooo");

    // reset while a read response is stalled
    in_data = '0;
    axi_write(8'h08, 32'hF, 4'hF, "wr MASK F pre-reset");
    repeat (SS + 2) tick();
    check("irq pre-reset", 32'(irq), 32'h1);
    S_AXI_ARADDR = 8'h0C; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    repeat (2) tick();
    check("stall rvalid held", 32'(S_AXI_RVALID), 32'h1);
    check("stall rdata held", S_AXI_RDATA, 32'hCAFE_F00D);
    ARESET = 1'b1;
    tick();
    check("mid rst rvalid", 32'(S_AXI_RVALID), 32'h0);
    check("mid rst rdata", S_AXI_RDATA, 32'h0);
    check("mid rst irq", 32'(irq), 32'h0);
    check("mid rst arready", 32'(S_AXI_ARREADY), 32'h0);
    ARESET = 1'b0;
    repeat (2) tick();
    axi_read(8'h00, 32'h0, "post rst CTRL");
    axi_read(8'h04, 32'h0, "post rst STATUS");
    axi_read(8'h08, 32'h0, "post rst MASK");
    axi_read(8'h0C, 32'h0, "post rst SCRATCH");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
